// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-road traffic light controller with timed green/yellow/clearance
// phases; the pedestrian WALK phase is compiled in only when PED_WALK_EN is defined.
module intersection_ctrl #(
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int CLR_CYC    = 2,
    parameter int WALK_CYC   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);
    localparam logic [2:0] ALL_RED_A = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] ALL_RED_B = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;
    localparam logic [2:0] WALK      = 3'd6;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    localparam logic [CNT_W-1:0] GREEN_END  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_END    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_CYC - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             ped_pending;
    logic             ret_ew;
    logic             walk_entry;
    logic [1:0]       ns_nxt, ew_nxt;
    logic             walk_nxt;

    assign phase      = state;
    assign walk_entry = (state_nxt == WALK) && (state != WALK);

`ifdef PED_WALK_EN
    // latch pedestrian demand until WALK is entered; a new request on that same edge wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
            ret_ew      <= 1'b0;
        end else begin
            ped_pending <= ped_req | (ped_pending & ~walk_entry);
            if (walk_entry)
                ret_ew <= (state == ALL_RED_B);
        end
    end
`else
    assign ped_pending = 1'b0 & ped_req;
    assign ret_ew      = 1'b0 & walk_entry;
`endif

    // state register and per-state cycle counter (cleared on entry, saturating)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ALL_RED_A;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= (state_nxt != state) ? '0 : (&count ? count : count + 1'b1);
        end
    end

    // next-state: each timed phase exits once its counter reaches duration-1
    always_comb begin
        state_nxt = state;
        case (state)
            ALL_RED_A: if (count >= CLR_END) state_nxt = ped_pending ? WALK : NS_GREEN;
            NS_GREEN:  if (count >= GREEN_END && (ew_req || ped_pending)) state_nxt = NS_YELLOW;
            NS_YELLOW: if (count >= YELLOW_END) state_nxt = ALL_RED_B;
            ALL_RED_B: if (count >= CLR_END) state_nxt = ped_pending ? WALK : EW_GREEN;
            EW_GREEN:  if (count >= GREEN_END && (ns_req || ped_pending)) state_nxt = EW_YELLOW;
            EW_YELLOW: if (count >= YELLOW_END) state_nxt = ALL_RED_A;
            WALK:      if (count >= WALK_END) state_nxt = ret_ew ? EW_GREEN : NS_GREEN;
            default:   state_nxt = ALL_RED_A;
        endcase
    end

    // lamp decode from the next state so lamps switch on the same edge as phase
    always_comb begin
        ns_nxt   = (state_nxt == NS_GREEN) ? GREEN : (state_nxt == NS_YELLOW) ? YELLOW : RED;
        ew_nxt   = (state_nxt == EW_GREEN) ? GREEN : (state_nxt == EW_YELLOW) ? YELLOW : RED;
        walk_nxt = (state_nxt == WALK);
    end

    // registered lamp outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ns_light <= RED;
            ew_light <= RED;
            walk     <= 1'b0;
        end else begin
            ns_light <= ns_nxt;
            ew_light <= ew_nxt;
            walk     <= walk_nxt;
        end
    end
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed phase-sequence checks for intersection_ctrl
module tb_intersection_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] ns_light, ew_light;
    logic       walk;
    logic [2:0] phase;
    int         n_vec = 0;
    int         n_err = 0;

    intersection_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {phase, ns_light, ew_light, walk} expected for a given phase
    function automatic logic [7:0] expect_of(input logic [2:0] ph);
        return {ph,
                (ph == 3'd1) ? 2'b01 : (ph == 3'd2) ? 2'b10 : 2'b00,
                (ph == 3'd4) ? 2'b01 : (ph == 3'd5) ? 2'b10 : 2'b00,
                ph == 3'd6};
    endfunction

    // check the current cycle, then advance one cycle; repeated n times
    task automatic run(input string tag, input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), {phase, ns_light, ew_light, walk}, expect_of(ph));
            @(negedge clk);
        end
    endtask

    task automatic restart(input logic ns, input logic ew, input logic ped);
        reset_n = 1'b0;
        ns_req  = ns;
        ew_req  = ew;
        ped_req = ped;
        repeat (2) @(negedge clk);
        check("in_reset", {phase, ns_light, ew_light, walk}, 8'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        restart(1'b0, 1'b0, 1'b0);
        run("idle_clr", 3'd0, 2);
        run("idle_ns", 3'd1, 100);
        ew_req = 1'b1;
        run("late_ns", 3'd1, 1);
        run("late_y", 3'd2, 3);
        run("late_b", 3'd3, 2);
        ew_req = 1'b0;
        run("late_ew", 3'd4, 10);

        restart(1'b0, 1'b1, 1'b0);
        run("ew_clr", 3'd0, 2);
        run("ew_nsg", 3'd1, 8);
        run("ew_nsy", 3'd2, 3);
        run("ew_b", 3'd3, 2);
        run("ew_rest", 3'd4, 20);
        ns_req = 1'b1;
        run("rst_ewg", 3'd4, 1);
        run("rst_ewy", 3'd5, 1);
        check("rst_y2", phase, 3'd5);
        reset_n = 1'b0;
        #1;
        check("async_rst", {phase, ns_light, ew_light, walk}, 8'd0);
        ew_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run("post_clr", 3'd0, 2);
        run("post_ns", 3'd1, 10);

`ifdef PED_WALK_EN
        restart(1'b0, 1'b0, 1'b0);
        run("ped_clr", 3'd0, 2);
        run("ped_g", 3'd1, 2);
        ped_req = 1'b1;
        run("ped_g3", 3'd1, 1);
        ped_req = 1'b0;
        run("ped_g48", 3'd1, 5);
        run("ped_y", 3'd2, 3);
        run("ped_b", 3'd3, 2);
        run("ped_walk", 3'd6, 6);
        run("ped_ew", 3'd4, 15);

        restart(1'b0, 1'b0, 1'b0);
        run("dbl_clr", 3'd0, 2);
        run("dbl_g", 3'd1, 2);
        ped_req = 1'b1;
        run("dbl_g3", 3'd1, 1);
        ped_req = 1'b0;
        run("dbl_g48", 3'd1, 5);
        run("dbl_y", 3'd2, 3);
        run("dbl_b1", 3'd3, 1);
        ped_req = 1'b1;
        ns_req  = 1'b1;
        run("dbl_b2", 3'd3, 1);
        ped_req = 1'b0;
        run("dbl_walk1", 3'd6, 6);
        run("dbl_ewg", 3'd4, 8);
        run("dbl_ewy", 3'd5, 3);
        run("dbl_a", 3'd0, 2);
        run("dbl_walk2", 3'd6, 6);
        run("dbl_ns", 3'd1, 10);
`else
        restart(1'b0, 1'b0, 1'b1);
        run("noped_clr", 3'd0, 2);
        run("noped_ns", 3'd1, 40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CNT_W, 8, phase counter width in bits.
- GREEN_CYC, 8, minimum green duration in cycles.
- YELLOW_CYC, 3, yellow duration in cycles.
- CLR_CYC, 2, all-red clearance duration in cycles.
- WALK_CYC, 6, pedestrian walk duration in cycles.
REQ-002 Every duration parameter SHALL be in the range 1 to 2^CNT_W-1; other values are unsupported.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ns_req  input  1  north-south vehicle demand (level).
- ew_req  input  1  east-west vehicle demand (level).
- ped_req  input  1  pedestrian request (pulse or level).
- ns_light  output  2  north-south lamp: 00 RED, 01 GREEN, 10 YELLOW.
- ew_light  output  2  east-west lamp, same encoding.
- walk  output  1  pedestrian walk lamp.
- phase  output  3  current state encoding.

Function
REQ-004 The states and their encodings SHALL be: ALL_RED_A=0 (clearance before NS green), NS_GREEN=1, NS_YELLOW=2, ALL_RED_B=3 (clearance before EW green), EW_GREEN=4, EW_YELLOW=5, WALK=6; encoding 7 SHALL be unreachable and SHALL return to ALL_RED_A on the next edge.
REQ-005 A CNT_W-bit counter SHALL clear on every state entry and increment each cycle the state is held, saturating at all-ones.
REQ-006 A state with duration D SHALL be held for exactly D cycles, and its exit condition SHALL be evaluated when count >= D-1.
REQ-007 NS_GREEN SHALL exit to NS_YELLOW when count >= GREEN_CYC-1 and (ew_req or ped_pending); otherwise it SHALL rest in green indefinitely.
REQ-008 EW_GREEN SHALL behave the same way with ns_req replacing ew_req, exiting to EW_YELLOW.
REQ-009 NS_YELLOW SHALL go to ALL_RED_B after YELLOW_CYC cycles, and EW_YELLOW SHALL go to ALL_RED_A after YELLOW_CYC cycles.
REQ-010 At the expiry of CLR_CYC, an ALL_RED state SHALL go to WALK if ped_pending is set, otherwise to its own green (A to NS_GREEN, B to EW_GREEN).
REQ-011 On entry to WALK, a 1-bit return register SHALL record the green that would otherwise have followed; WALK SHALL last WALK_CYC cycles and then enter that green.
REQ-012 ped_pending SHALL be set on any edge sampling ped_req=1 and cleared on the edge that enters WALK; when set and clear coincide, set SHALL win, giving a second WALK at the next ALL_RED.
REQ-013 Outputs SHALL be registered and decoded from the next state, so that lamps change on the same edge as phase.
REQ-014 walk SHALL be 1 only in WALK; both lamps SHALL be RED in ALL_RED_A, ALL_RED_B and WALK; at no time SHALL both lamps be non-RED.
REQ-015 ped_req sampled at edge k SHALL be able to influence a transition no earlier than edge k+1.

Reset
REQ-016 reset_n=0 SHALL immediately, without a clock edge, force phase=0, ns_light=00, ew_light=00, walk=0, count=0, ped_pending=0 and the return register to NS.
REQ-017 Reset asserted mid-phase SHALL abandon the phase with no yellow or clearance completion; after release, operation SHALL start with CLR_CYC cycles of ALL_RED_A.

Configuration
REQ-018 With macro PED_WALK_EN defined, the WALK state, ped_pending and the return register SHALL be compiled in as specified above.
REQ-019 Without PED_WALK_EN, ped_req SHALL be ignored, walk SHALL be constant 0, phase SHALL never equal 6, and green exit SHALL depend on cross-road demand only.

Verification (default parameters, PED_WALK_EN defined unless noted)
REQ-020 Release reset with ns_req=ew_req=ped_req=0 -> 2 cycles of phase=0 with both lamps RED, then phase=1 with ns_light=01, held for 100+ cycles.
REQ-021 Hold ew_req=1 and ns_req=0 from reset -> NS_GREEN 8 cycles, NS_YELLOW 3 cycles, ALL_RED_B 2 cycles, then EW_GREEN rests.
REQ-022 1-cycle ped_req pulse on the 3rd cycle of NS_GREEN with ew_req=0 -> green ends after cycle 8, then YELLOW 3 cycles, ALL_RED_B 2 cycles, WALK 6 cycles with walk=1, then EW_GREEN.
REQ-023 ped_req=1 on the edge that enters WALK -> after WALK, EW_GREEN, EW_YELLOW and ALL_RED_A run (with ns_req=1), then a second WALK, then NS_GREEN.
REQ-024 reset_n=0 during the 2nd cycle of EW_YELLOW -> same delta cycle gives phase=0 and both lamps=00; after release, 2 cycles of ALL_RED_A precede NS_GREEN.
REQ-025 PED_WALK_EN undefined, ped_req held 1, ew_req=0 -> walk stays 0, phase never equals 6, and NS_GREEN rests.
